row_buffer_ctrl_5rows: RTL

Controller for the 4-row line-buffer bank. It consumes the raster pixel stream and drives the bank's write port A and read port B for all four row RAMs, rotating which RAM receives the oldest row. For every input pixel, once 4 rows are buffered, it emits an aligned vertical 5-pixel column: 4 buffered rows plus the live pixel. That column feeds the downstream 5x5 window/filter stage.

---
 rtl/row_buffer_ctrl_5rows_pkg.sv | 19 +
 rtl/row_buffer_ctrl_5rows_rotate_mux.sv | 20 ++
 rtl/row_buffer_ctrl_5rows.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/row_buffer_ctrl_5rows_pkg.sv
// Shared constants for the 4-row line-buffer controller: number of row RAMs
// and the derived select/fill counter widths.
package row_buffer_ctrl_5rows_pkg;

   localparam int unsigned ROWS_BUFFERED = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   localparam int unsigned SEL_W  = clog2(ROWS_BUFFERED);
   localparam int unsigned FILL_W = clog2(ROWS_BUFFERED + 1);

endpackage

// File: rtl/row_buffer_ctrl_5rows_rotate_mux.sv
// Reorders the four row-RAM outputs so that rows[0] is the oldest buffered row,
// given the RAM index that currently holds it.
module row_rotate_mux
   import row_buffer_ctrl_5rows_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = 8
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic [P_DATA_WIDTH-1:0] dout [ROWS_BUFFERED],
   output logic [P_DATA_WIDTH-1:0] rows [ROWS_BUFFERED]
);

   always_comb begin
      for (int unsigned k = 0; k < ROWS_BUFFERED; k++) begin
         // index arithmetic wraps modulo the RAM count through SEL_W
         rows[k] = dout[sel + SEL_W'(k)];
      end
   end

endmodule

// File: rtl/row_buffer_ctrl_5rows.sv
// Line-buffer controller: drives four row RAMs (write A / read B) and emits an
// aligned 5-pixel vertical column per input pixel once four rows are stored.
module row_buffer_ctrl_5rows
   import row_buffer_ctrl_5rows_pkg::*;
#(
   parameter int unsigned P_ROW_WIDTH  = 256,
   parameter int unsigned P_DATA_WIDTH = 8,
   parameter int unsigned P_ADDR_WIDTH = 12
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_sof,
   input  logic                    i_pix_valid,
   input  logic [P_DATA_WIDTH-1:0] i_pix_data,
   output logic [P_ADDR_WIDTH-1:0] o_addra1,
   output logic [P_ADDR_WIDTH-1:0] o_addra2,
   output logic [P_ADDR_WIDTH-1:0] o_addra3,
   output logic [P_ADDR_WIDTH-1:0] o_addra4,
   output logic                    o_wea1,
   output logic                    o_wea2,
   output logic                    o_wea3,
   output logic                    o_wea4,
   output logic [P_DATA_WIDTH-1:0] o_dina1,
   output logic [P_DATA_WIDTH-1:0] o_dina2,
   output logic [P_DATA_WIDTH-1:0] o_dina3,
   output logic [P_DATA_WIDTH-1:0] o_dina4,
   output logic [P_ADDR_WIDTH-1:0] o_addrb1,
   output logic [P_ADDR_WIDTH-1:0] o_addrb2,
   output logic [P_ADDR_WIDTH-1:0] o_addrb3,
   output logic [P_ADDR_WIDTH-1:0] o_addrb4,
   output logic                    o_enb1,
   output logic                    o_enb2,
   output logic                    o_enb3,
   output logic                    o_enb4,
   input  logic [P_DATA_WIDTH-1:0] i_doutb1,
   input  logic [P_DATA_WIDTH-1:0] i_doutb2,
   input  logic [P_DATA_WIDTH-1:0] i_doutb3,
   input  logic [P_DATA_WIDTH-1:0] i_doutb4,
   output logic                    o_col_valid,
   output logic [P_DATA_WIDTH-1:0] o_col_row0,
   output logic [P_DATA_WIDTH-1:0] o_col_row1,
   output logic [P_DATA_WIDTH-1:0] o_col_row2,
   output logic [P_DATA_WIDTH-1:0] o_col_row3,
   output logic [P_DATA_WIDTH-1:0] o_col_row4,
   output logic [P_ADDR_WIDTH-1:0] o_col_x,
   output logic                    o_line_end
);

   localparam logic [P_ADDR_WIDTH-1:0] X_LAST = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
   localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(ROWS_BUFFERED);

   logic [P_ADDR_WIDTH-1:0] x_cnt, x_d, x_cur;
   logic [SEL_W-1:0]        wr_sel, wr_sel_d, sel_cur;
   logic [FILL_W-1:0]       fill_cnt, fill_cur;
   logic                    valid_d, full_d;
   logic [P_DATA_WIDTH-1:0] pix_d;
   logic [P_DATA_WIDTH-1:0] dout_arr [ROWS_BUFFERED];
   logic [P_DATA_WIDTH-1:0] rows_arr [ROWS_BUFFERED];
   logic [ROWS_BUFFERED-1:0] wea;
   logic                    col_vld;

   // start-of-frame overrides the stored position so a coincident pixel lands at col 0
   always_comb begin
      x_cur    = i_sof ? '0 : x_cnt;
      sel_cur  = i_sof ? '0 : wr_sel;
      fill_cur = i_sof ? '0 : fill_cnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_cnt    <= '0;
         wr_sel   <= '0;
         fill_cnt <= '0;
      end else if (i_pix_valid) begin
         if (x_cur == X_LAST) begin
            x_cnt    <= '0;
            wr_sel   <= sel_cur + SEL_W'(1);
            fill_cnt <= (fill_cur == FILL_FULL) ? fill_cur : fill_cur + FILL_W'(1);
         end else begin
            x_cnt    <= x_cur + P_ADDR_WIDTH'(1);
            wr_sel   <= sel_cur;
            fill_cnt <= fill_cur;
         end
      end else if (i_sof) begin
         x_cnt    <= '0;
         wr_sel   <= '0;
         fill_cnt <= '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_d  <= 1'b0;
         pix_d    <= '0;
         x_d      <= '0;
         wr_sel_d <= '0;
         full_d   <= 1'b0;
      end else begin
         valid_d <= i_pix_valid;
         if (i_pix_valid) begin
            pix_d    <= i_pix_data;
            x_d      <= x_cur;
            wr_sel_d <= sel_cur;
            full_d   <= (fill_cur == FILL_FULL);
         end
      end
   end

   always_comb begin
      dout_arr[0] = i_doutb1;
      dout_arr[1] = i_doutb2;
      dout_arr[2] = i_doutb3;
      dout_arr[3] = i_doutb4;
   end

   row_rotate_mux #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_rotate (
      .sel  (wr_sel_d),
      .dout (dout_arr),
      .rows (rows_arr)
   );

   // write-back lags the read by one cycle so the old row is read before it is replaced
   always_comb begin
      wea = '0;
      for (int unsigned k = 0; k < ROWS_BUFFERED; k++) begin
         wea[k] = valid_d && (wr_sel_d == SEL_W'(k));
      end
   end

   assign {o_wea4, o_wea3, o_wea2, o_wea1} = wea;
   assign o_addra1 = x_d;
   assign o_addra2 = x_d;
   assign o_addra3 = x_d;
   assign o_addra4 = x_d;
   assign o_dina1  = pix_d;
   assign o_dina2  = pix_d;
   assign o_dina3  = pix_d;
   assign o_dina4  = pix_d;

   assign o_addrb1 = x_cur;
   assign o_addrb2 = x_cur;
   assign o_addrb3 = x_cur;
   assign o_addrb4 = x_cur;
   assign o_enb1   = i_pix_valid;
   assign o_enb2   = i_pix_valid;
   assign o_enb3   = i_pix_valid;
   assign o_enb4   = i_pix_valid;

   // column data is zeroed when not valid so stale RAM contents never leak out
   assign col_vld     = valid_d & full_d;
   assign o_col_valid = col_vld;
   assign o_col_row0  = col_vld ? rows_arr[0] : '0;
   assign o_col_row1  = col_vld ? rows_arr[1] : '0;
   assign o_col_row2  = col_vld ? rows_arr[2] : '0;
   assign o_col_row3  = col_vld ? rows_arr[3] : '0;
   assign o_col_row4  = col_vld ? pix_d : '0;
   assign o_col_x     = x_d;
   assign o_line_end  = col_vld & (x_d == X_LAST);

endmodule
